// File: rtl/hamming_decode_seq.sv
// Byte-serial SECDED Hamming(16,11) decoder.
// Collects a 16-bit codeword as two bytes (LSW then MSW), computes the
// syndrome and overall parity in a dedicated cycle, then holds the decoded
// word and its status until the consumer takes it. Two saturating counters
// track corrected and detected-uncorrectable results.
module hamming_decode_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [10:0]      out_data_o,
    output logic [1:0]       out_status_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic [CNT_W-1:0] derr_cnt_o
);

    typedef enum logic [1:0] {
        WAIT_LSW = 2'd0,
        WAIT_MSW = 2'd1,
        CALC     = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_DERR  = 2'b10;

    state_e           state_q;
    logic [7:0]       lsw_q, msw_q;
    logic [3:0]       syn_q;
    logic             par_q;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] corr_q, derr_q;

    logic [15:0]      cw;
    logic [3:0]       syn_d;
    logic             par_d;
    logic [1:0]       calc_status;
    logic [15:0]      cw_fix;
    logic             in_fire;

    // Status encoding shared by the output path and the counter update.
    function automatic logic [1:0] status_f(input logic [3:0] s, input logic p);
        if (p)            return ST_CORR;
        else if (s != 0)  return ST_DERR;
        else              return ST_CLEAN;
    endfunction

    assign cw      = {msw_q, lsw_q};
    assign in_fire = in_valid_i && in_ready_q;

    // Syndrome = XOR of set-bit positions; overall parity covers all 16 bits.
    always_comb begin
        syn_d = '0;
        for (int i = 1; i < 16; i++) begin
            if (cw[i]) syn_d = syn_d ^ 4'(i);
        end
        par_d       = ^cw;
        calc_status = status_f(syn_d, par_d);
    end

    // Output decode works only from registered state, so OUT_* stay stable in DONE.
    // A p0-only error (s=0) leaves the data bits untouched; a double error is
    // reported with the data extracted as received.
    always_comb begin
        cw_fix = cw;
        if (par_q && (syn_q != 4'd0)) cw_fix[syn_q] = ~cw[syn_q];
        out_data_o   = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
        out_status_o = status_f(syn_q, par_q);
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign corr_cnt_o  = corr_q;
    assign derr_cnt_o  = derr_q;

    // Control FSM: byte capture, one syndrome cycle, then hold until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LSW;
            lsw_q       <= '0;
            msw_q       <= '0;
            syn_q       <= '0;
            par_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LSW: begin
                    if (in_fire) begin
                        lsw_q   <= in_byte_i;
                        state_q <= WAIT_MSW;
                    end
                end
                WAIT_MSW: begin
                    if (in_fire) begin
                        msw_q      <= in_byte_i;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    syn_q       <= syn_d;
                    par_q       <= par_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= WAIT_LSW;
                    end
                end
                default: begin
                    state_q     <= WAIT_LSW;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating result counters; bumped once per result as CALC hands over to DONE,
    // with a clear on the same edge taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_q <= '0;
            derr_q <= '0;
        end else if (cnt_clr_i) begin
            corr_q <= '0;
            derr_q <= '0;
        end else if (state_q == CALC) begin
            if (calc_status == ST_CORR && corr_q != '1) corr_q <= corr_q + 1'b1;
            if (calc_status == ST_DERR && derr_q != '1) derr_q <= derr_q + 1'b1;
        end
    end

endmodule
